// File: rtl/uart_tx_sched_if.sv
// Handshake bundle shared by the requesters, the scheduler and the UART serializer.
// The master side drives requests and serializer status. The slave side is the scheduler.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-wide UART serializer among NUM_REQ requesters.
// It holds the grant for a packet, is capped by MAX_BURST and is dropped after HOLD_TIMEOUT idle cycles.
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_sched_if.slave     bus,
    output logic [NUM_REQ-1:0] grant,
    output logic               active
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  last_winner;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  cand;
    logic              winner_found;
    logic [7:0]        burst_cnt;
    logic [7:0]        hold_cnt;
    logic              last_lat;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] req_bytes [NUM_REQ];
    logic              take_grant;
    logic              accept;
    logic              hold_inc;
    logic              release_now;
    logic              reload;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign req_bytes[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // Scan downward so the last hit is the index nearest to last_winner + 1.
    always_comb begin
        winner       = last_winner;
        winner_found = 1'b0;
        cand         = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last_winner) + i) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        take_grant    = 1'b0;
        accept        = 1'b0;
        hold_inc      = 1'b0;
        release_now   = 1'b0;
        reload        = 1'b0;
        bus.req_ready = '0;
        bus.tx_start  = 1'b0;
        case (state)
            IDLE: begin
                if (winner_found) begin
                    take_grant = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                bus.req_ready = grant;
                // An offered byte beats a timeout landing in the same cycle.
                if (bus.req_valid[owner]) begin
                    accept     = 1'b1;
                    state_next = START;
                end else if (hold_cnt == 8'(HOLD_TIMEOUT - 1)) begin
                    release_now = 1'b1;
                    state_next  = IDLE;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            START: begin
                bus.tx_start = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                if (!bus.tx_busy) begin
                    if (last_lat || burst_cnt == 8'(MAX_BURST)) begin
                        release_now = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        reload     = 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= '0;
            owner       <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
            burst_cnt   <= '0;
            hold_cnt    <= '0;
            last_lat    <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            if (take_grant) begin
                grant     <= NUM_REQ'(1) << winner;
                owner     <= winner;
                burst_cnt <= '0;
                hold_cnt  <= '0;
            end
            if (accept) begin
                tx_data_q <= req_bytes[owner];
                last_lat  <= bus.req_last[owner];
                burst_cnt <= burst_cnt + 8'd1;
            end
            if (hold_inc) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
            if (reload) begin
                hold_cnt <= '0;
            end
            // A timeout release also advances the rotation past this owner.
            if (release_now) begin
                grant       <= '0;
                last_winner <= owner;
            end
        end
    end

    assign bus.tx_data = tx_data_q;
    assign active      = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requesters replay byte lists and a 10-cycle serializer model runs.
// Expected bytes and owners are queued per scenario and popped on every tx_start.
module tb_uart_tx_sched;
    localparam int NREQ     = 4;
    localparam int BUSY_LEN = 10;
    localparam int MAXQ     = 16;

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] grant;
    logic            active;

    uart_tx_sched_if #(.NUM_REQ(NREQ), .DATA_W(8)) bus ();

    uart_tx_sched #(
        .NUM_REQ(NREQ),
        .DATA_W(8),
        .MAX_BURST(4),
        .HOLD_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .grant(grant),
        .active(active)
    );

    int   checks = 0;
    int   errors = 0;
    int   start_count = 0;
    exp_t sb[$];

    logic [7:0] src_data [NREQ][MAXQ];
    logic       src_last [NREQ][MAXQ];
    int         src_len   [NREQ];
    int         src_base  [NREQ];
    int         src_taken [NREQ];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] first, input int count,
                                 input logic [15:0] last_mask);
        for (int k = 0; k < count; k++) begin
            src_data[idx][k] = first + 8'(k);
            src_last[idx][k] = last_mask[k];
        end
        src_base[idx] = src_taken[idx];
        src_len[idx]  = count;
    endtask

    task automatic expect_byte(input int idx, input logic [7:0] data);
        sb.push_back({4'(idx), data});
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Request data becomes visible just after the next edge, which marks cycle 0.
    task automatic go0();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) src_len[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_ready", 32'(bus.req_ready), 0);
        checkOutput("rst_tx_start", 32'(bus.tx_start), 0);
        checkOutput("rst_tx_data", 32'(bus.tx_data), 0);
        checkOutput("rst_active", 32'(active), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || active === 1'b1 || bus.tx_busy === 1'b1 || bus.req_valid != 0)
               && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_in_time", (n < limit) ? 32'd1 : 32'd0, 1);
        @(posedge clk);
        #2;
    endtask

    // Requester model: each one offers its list in order and advances on valid & ready.
    initial begin
        logic [NREQ-1:0] fired;
        int              pos;
        for (int i = 0; i < NREQ; i++) src_taken[i] = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            fired = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fired[i]) src_taken[i]++;
                pos = src_taken[i] - src_base[i];
                if (pos < src_len[i]) begin
                    bus.req_valid[i]        = 1'b1;
                    bus.req_data[i*8 +: 8]  = src_data[i][pos];
                    bus.req_last[i]         = src_last[i][pos];
                end else begin
                    bus.req_valid[i]        = 1'b0;
                    bus.req_data[i*8 +: 8]  = 8'h00;
                    bus.req_last[i]         = 1'b0;
                end
            end
        end
    end

    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (BUSY_LEN) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        exp_t       e;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.tx_start === 1'b1) begin
                start_count++;
                checkOutput("sb_expected_start", (sb.size() != 0) ? 32'd1 : 32'd0, 1);
                if (sb.size() != 0) begin
                    e  = sb.pop_front();
                    oh = '0;
                    oh[e.idx[1:0]] = 1'b1;
                    checkOutput("sb_tx_data", 32'(bus.tx_data), 32'(e.data));
                    checkOutput("sb_tx_grant", 32'(grant), 32'(oh));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time %0t reached, required $finish before it", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0;
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            src_len[i]  = 0;
            src_base[i] = 0;
        end
        do_reset();

        $display("[TB] single byte");
        expect_byte(1, 8'h41);
        applyStimulus(1, 8'h41, 1, 16'h0001);
        go0();
        wait_neg(1);
        checkOutput("single_grant_c0", 32'(grant), 32'h0);
        wait_neg(1);
        checkOutput("single_grant_c1", 32'(grant), 32'h2);
        checkOutput("single_ready_c1", 32'(bus.req_ready), 32'h2);
        checkOutput("single_start_c1", 32'(bus.tx_start), 0);
        wait_neg(1);
        checkOutput("single_start_c2", 32'(bus.tx_start), 1);
        checkOutput("single_data_c2", 32'(bus.tx_data), 32'h41);
        wait_neg(11);
        checkOutput("single_grant_c13", 32'(grant), 32'h2);
        wait_neg(1);
        checkOutput("single_grant_c14", 32'(grant), 32'h0);
        checkOutput("single_active_c14", 32'(active), 0);
        wait_drain(200);

        $display("[TB] round robin");
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NREQ; i++) expect_byte(i, 8'(8'h20 + i*16 + r));
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'(8'h20 + i*16), 3, 16'h0007);
        go0();
        wait_neg(2);
        checkOutput("rr_first_grant", 32'(grant), 32'h1);
        wait_drain(2000);

        $display("[TB] packet hold");
        expect_byte(2, 8'h10);
        expect_byte(2, 8'h11);
        expect_byte(2, 8'h12);
        expect_byte(0, 8'h50);
        applyStimulus(2, 8'h10, 3, 16'h0004);
        go0();
        wait_neg(2);
        checkOutput("pkt_grant_c1", 32'(grant), 32'h4);
        applyStimulus(0, 8'h50, 1, 16'h0001);
        wait_drain(2000);

        $display("[TB] burst cap");
        for (int k = 0; k < 4; k++) expect_byte(3, 8'(8'h30 + k));
        expect_byte(0, 8'h60);
        expect_byte(3, 8'h34);
        expect_byte(3, 8'h35);
        applyStimulus(3, 8'h30, 6, 16'h0000);
        applyStimulus(0, 8'h60, 1, 16'h0001);
        go0();
        wait_neg(2);
        checkOutput("burst_grant_c1", 32'(grant), 32'h8);
        wait_drain(2000);

        $display("[TB] hold timeout");
        expect_byte(1, 8'h70);
        expect_byte(2, 8'h80);
        applyStimulus(1, 8'h70, 1, 16'h0000);
        applyStimulus(2, 8'h80, 1, 16'h0001);
        go0();
        wait_neg(22);
        checkOutput("timeout_grant_c21", 32'(grant), 32'h2);
        wait_neg(1);
        checkOutput("timeout_grant_c22", 32'(grant), 32'h0);
        wait_neg(1);
        checkOutput("timeout_grant_c23", 32'(grant), 32'h4);
        wait_drain(2000);

        $display("[TB] reset mid-WAIT");
        expect_byte(0, 8'h90);
        applyStimulus(0, 8'h90, 1, 16'h0001);
        go0();
        wait_neg(6);
        checkOutput("rstw_active_c5", 32'(active), 1);
        reset = 1'b1;
        wait_neg(1);
        checkOutput("rstw_grant", 32'(grant), 0);
        checkOutput("rstw_ready", 32'(bus.req_ready), 0);
        checkOutput("rstw_tx_start", 32'(bus.tx_start), 0);
        checkOutput("rstw_tx_data", 32'(bus.tx_data), 0);
        checkOutput("rstw_active", 32'(active), 0);
        reset = 1'b0;
        s0 = start_count;
        wait_neg(20);
        checkOutput("rstw_no_start", 32'(start_count - s0), 0);
        expect_byte(2, 8'hA0);
        expect_byte(3, 8'hB0);
        applyStimulus(2, 8'hA0, 1, 16'h0001);
        applyStimulus(3, 8'hB0, 1, 16'h0001);
        go0();
        wait_neg(2);
        checkOutput("rstw_new_grant", 32'(grant), 32'h4);
        wait_drain(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one byte-wide UART transmitter among NUM_REQ requesters. It sits between the producers (command responders, debug/status reporters) and the `uart_tx` serializer. It grants one requester at a time, can hold the grant for a packet of bytes, captures each byte and pulses the serializer start. It then waits for the frame to finish before moving to the next byte or requester.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width
- MAX_BURST, 16, maximum bytes per grant (1..255)
- HOLD_TIMEOUT, 64, idle cycles in LOAD mid-packet before the grant is forced off (1..255)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  NUM_REQ*DATA_W  per-requester byte, requester i at bits [i*DATA_W +: DATA_W]
- req_last  input  NUM_REQ  byte is last of packet; releases grant after it is sent
- req_ready  output  NUM_REQ  byte accepted when valid&ready; at most one bit set
- grant  output  NUM_REQ  one-hot current owner, 0 when idle
- tx_start  output  1  one-cycle start pulse to serializer
- tx_data  output  DATA_W  byte to serialize, stable from tx_start until tx_busy falls
- tx_busy  input  1  serializer busy; high the cycle after tx_start until frame end
- active  output  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, START, WAIT.
- IDLE: if any req_valid, select the winner by round robin, searching from last_winner+1 upward with wrap. Register it in grant, clear burst_cnt and hold_cnt, and go to LOAD.
- LOAD: req_ready[g] = 1 combinationally for the granted index only.
  - On req_valid[g]: capture req_data[g] into tx_data, latch req_last[g], increment burst_cnt, go to START.
  - Otherwise increment hold_cnt. When hold_cnt reaches HOLD_TIMEOUT, release the grant and return to IDLE.
  - If burst_cnt = 0 (first byte of grant), the timeout applies identically.
- START: tx_start = 1 for exactly this cycle, then WAIT.
- WAIT: remain while tx_busy = 1. When tx_busy = 0:
  - If the latched last = 1 or burst_cnt = MAX_BURST: release. last_winner <= g, grant <= 0, go to IDLE.
  - Otherwise clear hold_cnt and return to LOAD for the same requester.
- Release always updates last_winner to the released index, timeout releases included.
- Requests arriving while another requester is granted are held off; they are never dropped by this block.
- burst_cnt is 8 bits and saturation is not needed: release occurs at MAX_BURST.
- Requesters must hold valid/data stable until ready; a byte is never accepted without ready.

## Timing
- Reset values: grant = 0, req_ready = 0, tx_start = 0, tx_data = 0, active = 0, last_winner = NUM_REQ-1 so requester 0 has first priority, state = IDLE.
- Reset mid-operation returns to IDLE on the next edge. Any serializer frame already started is not aborted by this block.
- First byte latency: request seen in IDLE at cycle 0, grant and ready at cycle 1, accepted at cycle 1 if valid, tx_start at cycle 2.
- In-burst byte turnaround: tx_busy low at cycle N, LOAD at N+1 (byte accepted if valid), tx_start at N+2.
- Requester change: WAIT exit at cycle N, IDLE at N+1, new grant at N+2.
- Simultaneous requests in IDLE: exactly one is granted, and the order follows the rotating pointer.
- If req_valid[g] drops in the same cycle as a timeout, the timeout wins. If valid and timeout coincide, the byte is accepted.

## Test plan
- Single byte: reset, then req_valid[1] = 1, data 0x41, last = 1.
  - Required: grant = 4'b0010 at cycle 1, ready[1] at cycle 1, tx_start with tx_data = 0x41 at cycle 2.
  - Model busy for 10 cycles. Grant drops one cycle after busy falls.
- Round robin: all four requesters hold single-byte packets continuously.
  - Required: grants in the sequence 0,1,2,3,0,…
  - After reset the first grant is 0.
- Packet hold: requester 2 sends 0x10, 0x11, 0x12 with last on 0x12 while requester 0 also requests.
  - Required: all three bytes are serialized consecutively before grant moves to 3 (none pending) or 0.
- Burst cap: MAX_BURST = 4, requester 3 sends 6 bytes and never asserts last, with requester 0 also requesting.
  - Required: release after the 4th tx_start, and requester 0 is granted next.
- Hold timeout: HOLD_TIMEOUT = 8, requester 1 sends one byte with last = 0, then drops valid.
  - Required: grant releases exactly 8 cycles after re-entering LOAD.
  - A pending requester 2 is granted next.
- Reset mid-WAIT: assert reset during tx_busy.
  - Required: all outputs return to reset values on the next edge, and no tx_start is issued until a new request arrives.
